// File: rtl/dff_pipe_en.sv
// Stallable, flushable WIDTH x DEPTH register pipeline with per-stage valid bits,
// valid/ready handshakes on both ends and bubble collapsing toward the output.
module dff_pipe_en #(
  parameter int                WIDTH     = 8,
  parameter int                DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}},
  parameter int                OCC_W     = $clog2(DEPTH+1)
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Qo,
  output logic [OCC_W-1:0] occupancy
);

  // Handshake: a beat transfers on a rising edge only when valid and ready are
  // both high in that cycle with clk_en=1 and flush=0; valid never waits on ready.

  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [DEPTH-1:0]            v_q, v_d;
  logic [OCC_W-1:0]            occ_q, occ_d;
  logic [DEPTH-1:0]            rdy;
  logic                        advance;
  logic                        in_fire;
  logic                        out_fire;
  logic                        rdy_acc;

  // rdy[i]: stage i is empty or its occupant moves on this edge.
  always_comb begin
    rdy_acc = out_ready;
    rdy     = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      rdy_acc = rdy_acc | ~v_q[i];
      rdy[i]  = rdy_acc;
    end
  end

  always_comb begin
    advance  = clk_en & ~flush;
    in_ready = advance & rdy[0];
    in_fire  = in_valid & in_ready;
    out_fire = advance & v_q[DEPTH-1] & out_ready;
  end

  always_comb begin
    d_d   = d_q;
    v_d   = v_q;
    occ_d = occ_q;
    if (clk_en && flush) begin
      d_d   = {DEPTH{RESET_VAL}};
      v_d   = '0;
      occ_d = '0;
    end else if (advance) begin
      for (int i = DEPTH-1; i > 0; i--) begin
        if (rdy[i]) begin
          d_d[i] = d_q[i-1];
          v_d[i] = v_q[i-1];
        end
      end
      if (rdy[0]) begin
        d_d[0] = Din;
        v_d[0] = in_fire;
      end
      if (in_fire && !out_fire) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (out_fire && !in_fire) begin
        occ_d = occ_q - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      d_q   <= {DEPTH{RESET_VAL}};
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      d_q   <= d_d;
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign Qo        = d_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule
